// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache slice: bus command encoding,
// cache line metadata layout, default geometry and the miss-unit state type.
package icache_pkg;

  localparam int unsigned SUPERSCALAR_WAYS = 2;
  localparam int unsigned SYS_XLEN         = 32;
  localparam int unsigned ICACHE_LINES     = 32;
  localparam int unsigned IDX_BITS         = $clog2(ICACHE_LINES);
  localparam int unsigned TAG_BITS         = SYS_XLEN - 3 - IDX_BITS;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
  } ICACHE_LINE;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_REQ,
    MS_WAIT
  } miss_state_t;

endpackage

// File: rtl/icache_miss_unit.sv
// Single-outstanding miss handler for the instruction cache.
// Ports:
//   clock, reset_n         clock and asynchronous active-low reset
//   any_miss, miss_block   a lookup missed; block address of lowest missing way
//   grant, response, tag   memory bus handshake and completion tag
//   command, mem_addr      bus command and block address being requested
//   fill_en/idx/tag        line write strobe with target index and tag
module icache_miss_unit
  import icache_pkg::*;
#(
  parameter int unsigned XLEN = SYS_XLEN,
  parameter int unsigned IB   = IDX_BITS,
  parameter int unsigned TB   = TAG_BITS
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            any_miss,
  input  logic [XLEN-1:0] miss_block,
  input  logic            grant,
  input  logic [3:0]      response,
  input  logic [3:0]      tag,
  output BUS_COMMAND      command,
  output logic [XLEN-1:0] mem_addr,
  output logic            fill_en,
  output logic [IB-1:0]   fill_idx,
  output logic [TB-1:0]   fill_tag
);

  miss_state_t     state, next_state;
  logic [XLEN-1:0] miss_addr;
  logic [3:0]      wait_tag;
  logic            accept;

  assign accept = (state == MS_REQ) && grant && (response != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= MS_IDLE;
      miss_addr <= '0;
      wait_tag  <= '0;
    end else begin
      state <= next_state;
      if (state == MS_IDLE && any_miss) miss_addr <= miss_block;
      if (accept) wait_tag <= response;
    end
  end

  always_comb begin
    next_state = state;
    command    = BUS_NONE;
    fill_en    = 1'b0;
    case (state)
      MS_IDLE: if (any_miss) next_state = MS_REQ;
      MS_REQ: begin
        command = BUS_LOAD;
        if (accept) next_state = MS_WAIT;
      end
      MS_WAIT: begin
        if (tag != '0 && tag == wait_tag) begin
          fill_en    = 1'b1;
          next_state = MS_IDLE;
        end
      end
      default: next_state = MS_IDLE;
    endcase
  end

  assign mem_addr = miss_addr;
  assign fill_idx = miss_addr[3 +: IB];
  assign fill_tag = miss_addr[XLEN-1 -: TB];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache answering WAYS fetch lookups per cycle.
// Ports:
//   clock, reset_n                    clock and asynchronous active-low reset
//   proc2Icache_addr                  per-way fetch address (bits [2:0] ignored)
//   Icache2proc_data/valid            per-way line data and hit flag
//   proc2mem_command, proc2mem_addr   miss load request to the memory bus
//   Imem_bus_grant, mem2proc_*        arbiter grant, acceptance tag, completion
module icache
  import icache_pkg::*;
#(
  parameter int unsigned WAYS      = SUPERSCALAR_WAYS,
  parameter int unsigned NUM_LINES = ICACHE_LINES,
  parameter int unsigned XLEN      = SYS_XLEN
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [WAYS-1:0][XLEN-1:0] proc2Icache_addr,
  output logic [WAYS-1:0][63:0]     Icache2proc_data,
  output logic [WAYS-1:0]           Icache2proc_valid,
  output BUS_COMMAND                proc2mem_command,
  output logic [XLEN-1:0]           proc2mem_addr,
  input  logic                      Imem_bus_grant,
  input  logic [3:0]                mem2proc_response,
  input  logic [3:0]                mem2proc_tag,
  input  logic [63:0]               mem2proc_data
);

  localparam int unsigned IB = $clog2(NUM_LINES);
  localparam int unsigned TB = XLEN - 3 - IB;

  logic [NUM_LINES-1:0] line_valid;
  logic [TB-1:0]        line_tag  [NUM_LINES];
  logic [63:0]          line_data [NUM_LINES];

  logic            fill_en;
  logic [IB-1:0]   fill_idx;
  logic [TB-1:0]   fill_tag;
  logic            any_miss;
  logic [XLEN-1:0] miss_block;
  logic            unused_offset;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) line_valid <= '0;
    else if (fill_en) line_valid[fill_idx] <= 1'b1;
  end

  // Tag and data storage carry no reset; only the valid bits gate them.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      line_tag[fill_idx]  <= fill_tag;
      line_data[fill_idx] <= mem2proc_data;
    end
  end

  // Lookup plus lowest-index miss selection in one pass over the ways.
  always_comb begin
    logic [IB-1:0] idx;
    logic [TB-1:0] tag;
    logic          hit;
    Icache2proc_valid = '0;
    Icache2proc_data  = '0;
    any_miss          = 1'b0;
    miss_block        = '0;
    unused_offset     = 1'b0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      idx = proc2Icache_addr[i][3 +: IB];
      tag = proc2Icache_addr[i][XLEN-1 -: TB];
      hit = line_valid[idx] && (line_tag[idx] == tag);
      Icache2proc_valid[i] = hit;
      Icache2proc_data[i]  = line_data[idx];
      unused_offset        = unused_offset ^ (^proc2Icache_addr[i][2:0]);
      if (!hit && !any_miss) begin
        any_miss   = 1'b1;
        miss_block = {proc2Icache_addr[i][XLEN-1:3], 3'b000};
      end
    end
  end

  icache_miss_unit #(
    .XLEN (XLEN),
    .IB   (IB),
    .TB   (TB)
  ) u_miss (
    .clock      (clock),
    .reset_n    (reset_n),
    .any_miss   (any_miss),
    .miss_block (miss_block),
    .grant      (Imem_bus_grant),
    .response   (mem2proc_response),
    .tag        (mem2proc_tag),
    .command    (proc2mem_command),
    .mem_addr   (proc2mem_addr),
    .fill_en    (fill_en),
    .fill_idx   (fill_idx),
    .fill_tag   (fill_tag)
  );

endmodule
